conv_layer_walker: RTL and testbench

//  Layer-side responder to the CNN layer sequencer: takes a start pulse plus per-layer geometry and base

---
 rtl/conv_layer_walker_pkg.sv | 22 ++
 rtl/conv_layer_walker_idx_wrap_counter.sv | 48 ++++
 rtl/conv_layer_walker.sv | 239 +++++++++++++++++++++++
 tb/tb_conv_layer_walker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_walker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_layer_walker_pkg                                        |
// | Description : Shared widths, stride and walker FSM state encoding for the  |
// |               convolution layer walker and its index counters.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package conv_layer_walker_pkg;

   localparam int AW     = 13;   // address / dimension width
   localparam int STRIDE = 2;    // convolution stride, rows and columns

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_REQ  = 3'd2,
      ST_NEXT = 3'd3,
      ST_DONE = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_layer_walker_idx_wrap_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_layer_walker_idx_wrap_counter                           |
// | Description : W-bit index counter counting 0..limit-1 with clear and       |
// |               increment; wrap_o flags that the next increment returns to 0.|
// | Ports       : clk, rst (sync, active-low), clr_i, inc_i, limit_i,          |
// |               cnt_o (current index), wrap_o (cnt_o == limit_i-1)           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module conv_layer_walker_idx_wrap_counter #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic [W-1:0] limit_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic [W-1:0] w_cnt_inc;

   assign w_cnt_inc = cnt_q + {{(W-1){1'b0}}, 1'b1};
   assign wrap_o    = (w_cnt_inc == limit_i);
   assign cnt_o     = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = wrap_o ? '0 : w_cnt_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_layer_walker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_layer_walker                                            |
// | Description : Latches one layer's geometry on start_i, walks every output  |
// |               pixel (io, ir, ic) and issues one pixel job per output over  |
// |               a px_req_o/px_ack_i handshake, then pulses picture_finish_o. |
// | Ports       : clk, rst (sync, active-low), start_i, layer geometry and     |
// |               base addresses (*_i), px_req_o/px_ack_i handshake, job       |
// |               addresses and indices (*_o), busy_o, picture_finish_o        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module conv_layer_walker
   import conv_layer_walker_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic [AW-1:0] do_i,
   input  logic [AW-1:0] di_i,
   input  logic [AW-1:0] dc_i,
   input  logic [AW-1:0] dkr_i,
   input  logic [AW-1:0] dkc_i,
   input  logic [AW-1:0] dr_out_i,
   input  logic [AW-1:0] dc_out_i,
   input  logic [AW-1:0] inaddr_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [AW-1:0] outaddr_i,
   output logic          px_req_o,
   input  logic          px_ack_i,
   output logic [AW-1:0] in_addr_o,
   output logic [AW-1:0] w_addr_o,
   output logic [AW-1:0] out_addr_o,
   output logic [AW-1:0] io_out_o,
   output logic [AW-1:0] ir_out_o,
   output logic [AW-1:0] ic_out_o,
   output logic          busy_o,
   output logic          picture_finish_o
);

   localparam logic [AW-1:0] C_STRIDE = AW'(STRIDE);
   localparam logic [AW-1:0] C_ONE    = AW'(1);

   state_t        state_q, state_d;

   // Layer parameters, captured only on an accepted start
   logic [AW-1:0] do_q, di_q, dc_q, dkr_q, dkc_q, dr_q, dcout_q;
   logic [AW-1:0] inaddr_q, waddr_q, outaddr_q;

   logic [AW-1:0] wstep_q, wstep_d;
   logic [AW-1:0] rstep_q, rstep_d;
   logic [AW-1:0] in_row_q, in_row_d;
   logic [AW-1:0] in_addr_q, in_addr_d;
   logic [AW-1:0] w_addr_q, w_addr_d;
   logic [AW-1:0] out_addr_q, out_addr_d;
   logic          px_req_q, px_req_d;
   logic          busy_q, busy_d;
   logic          fin_q, fin_d;

   logic          w_latch;
   logic          w_prep;
   logic          w_step;
   logic          w_ic_wrap, w_ir_wrap, w_io_wrap;

   assign w_latch = (state_q == ST_IDLE) && start_i;
   assign w_prep  = (state_q == ST_PREP);
   assign w_step  = (state_q == ST_NEXT);

   // Nested index counters: columns advance every job, rows on column wrap,
   // output channels on row wrap.
   conv_layer_walker_idx_wrap_counter #(.W(AW)) u_ic (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (w_prep),
      .inc_i   (w_step),
      .limit_i (dcout_q),
      .cnt_o   (ic_out_o),
      .wrap_o  (w_ic_wrap)
   );

   conv_layer_walker_idx_wrap_counter #(.W(AW)) u_ir (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (w_prep),
      .inc_i   (w_step && w_ic_wrap),
      .limit_i (dr_q),
      .cnt_o   (ir_out_o),
      .wrap_o  (w_ir_wrap)
   );

   conv_layer_walker_idx_wrap_counter #(.W(AW)) u_io (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (w_prep),
      .inc_i   (w_step && w_ic_wrap && w_ir_wrap),
      .limit_i (do_q),
      .cnt_o   (io_out_o),
      .wrap_o  (w_io_wrap)
   );

   always_comb begin
      state_d    = state_q;
      wstep_d    = wstep_q;
      rstep_d    = rstep_q;
      in_row_d   = in_row_q;
      in_addr_d  = in_addr_q;
      w_addr_d   = w_addr_q;
      out_addr_d = out_addr_q;
      px_req_d   = 1'b0;
      busy_d     = busy_q;
      fin_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start_i) begin
               state_d = ST_PREP;
               busy_d  = 1'b1;
            end
         end

         ST_PREP: begin
            // The only multiply in the design; steps are reused by adds later.
            wstep_d    = di_q * dkr_q * dkc_q;
            rstep_d    = C_STRIDE * dc_q;
            in_row_d   = inaddr_q;
            in_addr_d  = inaddr_q;
            w_addr_d   = waddr_q;
            out_addr_d = outaddr_q;
            if ((do_q == '0) || (dr_q == '0) || (dcout_q == '0)) begin
               state_d = ST_DONE;
               fin_d   = 1'b1;
            end else begin
               state_d  = ST_REQ;
               px_req_d = 1'b1;
            end
         end

         ST_REQ: begin
            if (px_ack_i) begin
               state_d = ST_NEXT;
            end else begin
               px_req_d = 1'b1;
            end
         end

         ST_NEXT: begin
            out_addr_d = out_addr_q + C_ONE;
            if (!w_ic_wrap) begin
               in_addr_d = in_addr_q + C_STRIDE;
            end else if (!w_ir_wrap) begin
               in_row_d  = in_row_q + rstep_q;
               in_addr_d = in_row_q + rstep_q;
            end else begin
               in_row_d  = inaddr_q;
               in_addr_d = inaddr_q;
               w_addr_d  = w_addr_q + wstep_q;
            end
            if (w_ic_wrap && w_ir_wrap && w_io_wrap) begin
               state_d = ST_DONE;
               fin_d   = 1'b1;
            end else begin
               state_d  = ST_REQ;
               px_req_d = 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         wstep_q    <= '0;
         rstep_q    <= '0;
         in_row_q   <= '0;
         in_addr_q  <= '0;
         w_addr_q   <= '0;
         out_addr_q <= '0;
         px_req_q   <= 1'b0;
         busy_q     <= 1'b0;
         fin_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wstep_q    <= wstep_d;
         rstep_q    <= rstep_d;
         in_row_q   <= in_row_d;
         in_addr_q  <= in_addr_d;
         w_addr_q   <= w_addr_d;
         out_addr_q <= out_addr_d;
         px_req_q   <= px_req_d;
         busy_q     <= busy_d;
         fin_q      <= fin_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         do_q      <= '0;
         di_q      <= '0;
         dc_q      <= '0;
         dkr_q     <= '0;
         dkc_q     <= '0;
         dr_q      <= '0;
         dcout_q   <= '0;
         inaddr_q  <= '0;
         waddr_q   <= '0;
         outaddr_q <= '0;
      end else if (w_latch) begin
         do_q      <= do_i;
         di_q      <= di_i;
         dc_q      <= dc_i;
         dkr_q     <= dkr_i;
         dkc_q     <= dkc_i;
         dr_q      <= dr_out_i;
         dcout_q   <= dc_out_i;
         inaddr_q  <= inaddr_i;
         waddr_q   <= waddr_i;
         outaddr_q <= outaddr_i;
      end
   end

   assign px_req_o         = px_req_q;
   assign in_addr_o        = in_addr_q;
   assign w_addr_o         = w_addr_q;
   assign out_addr_o       = out_addr_q;
   assign busy_o           = busy_q;
   assign picture_finish_o = fin_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_walker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_conv_layer_walker                                         |
// | Description : Scoreboard bench for conv_layer_walker. Stimulus computes    |
// |               every expected pixel job from the layer geometry and queues  |
// |               it; a negedge monitor pops and compares on each handshake.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_conv_layer_walker;

   localparam int AW = 13;
   localparam int ST = 2;

   typedef struct packed {
      logic [AW-1:0] in_a;
      logic [AW-1:0] w_a;
      logic [AW-1:0] out_a;
      logic [AW-1:0] io;
      logic [AW-1:0] ir;
      logic [AW-1:0] ic;
   } job_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] d_o = '0, d_i = '0, d_c = '0, d_kr = '0, d_kc = '0;
   logic [AW-1:0] d_ro = '0, d_co = '0, ina = '0, wa = '0, outa = '0;
   logic          px_req;
   logic          px_ack = 1'b0;
   logic [AW-1:0] in_addr, w_addr, out_addr, io_out, ir_out, ic_out;
   logic          busy, picture_finish;

   job_t exp_q[$];
   int   fin_q[$];

   int errors = 0;
   int checks = 0;
   int jobs_in_layer = 0;
   int fin_seen = 0;
   int stall_cycles = 0;
   int ack_mode = 0;
   int hold_cnt = 0;

   logic  prev_stall = 1'b0;
   job_t  prev_job;

   conv_layer_walker dut (
      .clk              (clk),
      .rst              (rst),
      .start_i          (start),
      .do_i             (d_o),
      .di_i             (d_i),
      .dc_i             (d_c),
      .dkr_i            (d_kr),
      .dkc_i            (d_kc),
      .dr_out_i         (d_ro),
      .dc_out_i         (d_co),
      .inaddr_i         (ina),
      .waddr_i          (wa),
      .outaddr_i        (outa),
      .px_req_o         (px_req),
      .px_ack_i         (px_ack),
      .in_addr_o        (in_addr),
      .w_addr_o         (w_addr),
      .out_addr_o       (out_addr),
      .io_out_o         (io_out),
      .ir_out_o         (ir_out),
      .ic_out_o         (ic_out),
      .busy_o           (busy),
      .picture_finish_o (picture_finish)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic job_t cur_job();
      job_t j;
      j.in_a  = in_addr;
      j.w_a   = w_addr;
      j.out_a = out_addr;
      j.io    = io_out;
      j.ir    = ir_out;
      j.ic    = ic_out;
      return j;
   endfunction

   function automatic logic [127:0] all_outs();
      return {px_req, in_addr, w_addr, out_addr, io_out, ir_out, ic_out, busy, picture_finish};
   endfunction

   // Reference model: each job's addresses follow directly from its indices.
   task automatic build_model(input int o, input int i, input int c, input int kr, input int kc,
                              input int ro, input int co, input int ia, input int wb, input int ob,
                              output int n);
      job_t j;
      n = 0;
      for (int po = 0; po < o; po++)
         for (int pr = 0; pr < ro; pr++)
            for (int pc = 0; pc < co; pc++) begin
               j.in_a  = AW'(ia + pr * ST * c + pc * ST);
               j.w_a   = AW'(wb + po * i * kr * kc);
               j.out_a = AW'(ob + n);
               j.io    = AW'(po);
               j.ir    = AW'(pr);
               j.ic    = AW'(pc);
               exp_q.push_back(j);
               n++;
            end
   endtask

   // Acknowledge driver: 0 = always, 1 = random, 2 = hold off the third job 7 cycles
   always @(posedge clk) begin
      #1;
      case (ack_mode)
         0: px_ack = 1'b1;
         1: px_ack = 1'($urandom_range(0, 1));
         default: begin
            if (jobs_in_layer == 2 && px_req && hold_cnt < 7) begin
               px_ack = 1'b0;
               hold_cnt++;
            end else begin
               px_ack = 1'b1;
            end
         end
      endcase
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (px_req) begin
            if (prev_stall) check("stall_stable", cur_job(), prev_job);
            if (exp_q.size() == 0) begin
               if (px_ack) check("unexpected_req", 1'b1, 1'b0);
            end else if (px_ack) begin
               job_t e;
               e = exp_q.pop_front();
               check("job", cur_job(), e);
               jobs_in_layer++;
            end
            prev_stall = !px_ack;
            prev_job   = cur_job();
            if (!px_ack) stall_cycles++;
         end else begin
            prev_stall = 1'b0;
         end
         if (picture_finish) begin
            if (fin_q.size() == 0) begin
               check("unexpected_finish", 1'b1, 1'b0);
            end else begin
               int n;
               n = fin_q.pop_front();
               check("finish_jobs", jobs_in_layer, n);
               check("finish_queue_empty", exp_q.size(), 0);
               check("finish_busy", busy, 1'b1);
            end
            jobs_in_layer = 0;
            fin_seen++;
         end
      end
   end

   task automatic scramble_inputs();
      d_o  = AW'($urandom); d_i  = AW'($urandom); d_c  = AW'($urandom);
      d_kr = AW'($urandom); d_kc = AW'($urandom); d_ro = AW'($urandom);
      d_co = AW'($urandom); ina  = AW'($urandom); wa   = AW'($urandom);
      outa = AW'($urandom);
   endtask

   // Runs one layer; mid_start pulses start (with random params) after 100 jobs.
   // rst_at > 0 asserts reset once that many jobs have been accepted.
   task automatic run_layer(input int o, input int i, input int c, input int kr, input int kc,
                            input int ro, input int co, input int ia, input int wb, input int ob,
                            input bit mid_start, input int rst_at);
      int n, cnt, fs;
      bit mid_done;
      mid_done = 0;
      build_model(o, i, c, kr, kc, ro, co, ia, wb, ob, n);
      fin_q.push_back(n);
      fs = fin_seen;
      @(posedge clk); #2;
      d_o = AW'(o); d_i = AW'(i); d_c = AW'(c); d_kr = AW'(kr); d_kc = AW'(kc);
      d_ro = AW'(ro); d_co = AW'(co); ina = AW'(ia); wa = AW'(wb); outa = AW'(ob);
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      scramble_inputs();
      check("prep_busy", {busy, px_req, picture_finish}, 3'b100);
      @(posedge clk); #2;
      if (n == 0) check("empty_finish_latency", {px_req, picture_finish}, 2'b01);
      else        check("first_req_latency", {px_req, picture_finish}, 2'b10);
      cnt = 0;
      while (fin_seen == fs && cnt < 20000) begin
         @(posedge clk); #2;
         cnt++;
         start = 1'b0;
         if (mid_start && !mid_done && jobs_in_layer >= 100) begin
            scramble_inputs();
            start = 1'b1;
            mid_done = 1;
         end
         if (rst_at > 0 && jobs_in_layer >= rst_at) begin
            rst = 1'b0;
            @(posedge clk); #2;
            check("midlayer_reset_outputs", all_outs(), '0);
            exp_q.delete();
            fin_q.delete();
            jobs_in_layer = 0;
            rst = 1'b1;
            return;
         end
      end
      if (cnt >= 20000) check("layer_timeout", 1'b1, 1'b0);
      @(posedge clk); #2;
      check("post_finish_idle", {busy, picture_finish, px_req}, 3'b000);
   endtask

   initial begin
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("reset_outputs", all_outs(), '0);
      rst = 1'b1;
      @(posedge clk); #2;
      check("idle_after_reset", all_outs(), '0);

      // Layer A, acknowledge every request
      ack_mode = 0;
      run_layer(4, 1, 28, 4, 4, 13, 13, 1, 805, 1000, 0, 0);

      // Layer B, random acknowledge
      ack_mode = 1;
      run_layer(4, 4, 13, 5, 5, 5, 5, 1000, 2000, 3000, 0, 0);

      // Backpressure on the third job
      ack_mode = 2; hold_cnt = 0; stall_cycles = 0;
      run_layer(4, 4, 13, 5, 5, 5, 5, 1000, 2000, 3000, 0, 0);
      check("stall_cycles", stall_cycles, 7);

      // Start pulsed mid-layer with other params is ignored
      ack_mode = 1;
      run_layer(4, 1, 28, 4, 4, 13, 13, 1, 805, 1000, 1, 0);

      // Zero output rows: no requests, finish two cycles after start
      run_layer(4, 1, 28, 4, 4, 0, 13, 1, 805, 1000, 0, 0);

      // Reset mid-layer at job 50, then rerun from job 0
      run_layer(4, 4, 13, 5, 5, 5, 5, 1000, 2000, 3000, 0, 50);
      run_layer(4, 4, 13, 5, 5, 5, 5, 1000, 2000, 3000, 0, 0);

      // Random small geometries, wrapping base addresses
      for (int k = 0; k < 4; k++) begin
         run_layer($urandom_range(1, 3), $urandom_range(1, 8), $urandom_range(1, 4000),
                   $urandom_range(1, 7), $urandom_range(1, 7), $urandom_range(1, 4),
                   $urandom_range(1, 5), $urandom_range(0, 8191), $urandom_range(0, 8191),
                   $urandom_range(0, 8191), 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
